uart_rx_cmd_parser: RTL and testbench
=====================================

// Module: uart_rx_cmd_parser
// PURPOSE
//  Consumes the byte stream of the UART receiver (P_DATA / data_valid / error flags) and
//  decodes multi-byte command frames into single-cycle register-file and ALU strobes.
//  Sits directly downstream of the UART receiver, in the same clock domain.
//  Aborts partial frames on receive error or inter-byte timeout.
// PARAMETERS
//  DATA_W    8     byte width; must match the receiver data width
//  ADDR_W    4     register-file address width; addr = byte[ADDR_W-1:0], upper bits ignored
//  TIMEOUT   1023  idle cycles allowed between bytes of one frame before abort (>=1)
// PORTS
//  clk        in   1        system clock
//  rst        in   1        asynchronous, active-high reset
//  rx_data    in   DATA_W   received byte, valid when rx_valid=1
//  rx_valid   in   1        one-cycle pulse per received byte
//  rx_err     in   1        parity|stop error for the byte qualified by rx_valid
//  wr_en      out  1        one-cycle register write strobe
//  rd_en      out  1        one-cycle register read strobe
//  addr       out  ADDR_W   register address for wr_en/rd_en
//  wr_data    out  DATA_W   register write data
//  op_wr      out  1        one-cycle strobe: op_a/op_b valid for operand load
//  op_a       out  DATA_W   ALU operand A
//  op_b       out  DATA_W   ALU operand B
//  alu_en     out  1        one-cycle ALU execute strobe
//  alu_fun    out  4        ALU function code = byte[3:0]
//  busy       out  1        1 whenever state != IDLE
//  cmd_err    out  1        one-cycle pulse: unknown command byte in IDLE
//  frame_err  out  1        one-cycle pulse: frame aborted (rx_err or timeout)
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; timeout counter 0. Reset mid-frame drops the frame, no strobes.
//  Frames (first byte = command):
//   0xAA addr data      -> wr_en=1, addr, wr_data
//   0xBB addr           -> rd_en=1, addr
//   0xCC opA opB fun    -> op_wr=1 and alu_en=1 in the same cycle, op_a, op_b, alu_fun
//   0xDD fun            -> alu_en=1, alu_fun
//  States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, ALU_A, ALU_B, ALU_FUN_OP, ALU_FUN_NOP.
//   IDLE:     on rx_valid, AA->WR_ADDR, BB->RD_ADDR, CC->ALU_A, DD->ALU_FUN_NOP;
//             other byte -> stay IDLE, cmd_err pulse next cycle.
//   WR_ADDR->WR_DATA->IDLE, RD_ADDR->IDLE, ALU_A->ALU_B->ALU_FUN_OP->IDLE,
//   ALU_FUN_NOP->IDLE; each transition on rx_valid.
//  Latency: strobe asserted exactly 1 cycle after the rx_valid of the final byte; all strobes
//   are registered and high for exactly 1 cycle.
//  Data outputs (addr, wr_data, op_a, op_b, alu_fun) are registered on capture and hold until
//   overwritten by a later frame; they are not cleared after a strobe.
//  rx_valid with rx_err=1: byte discarded. In IDLE: frame_err pulse, stay IDLE. In any other
//   state: abort to IDLE, frame_err pulse, no command strobe.
//  Timeout: counter clears on every rx_valid and whenever state=IDLE; increments otherwise.
//   When counter==TIMEOUT-1 and rx_valid=0 -> IDLE, frame_err pulse; counter saturates, no wrap.
//   If rx_valid and timeout expiry coincide, the byte wins (normal transition, no frame_err).
//  A new command byte may arrive in the cycle the previous strobe is asserted; it is decoded normally.
//  cmd_err and frame_err are never asserted together.
// TESTING
//  AA,05,3C with 3 idle cycles between bytes -> wr_en 1 cycle after last byte, addr=5, wr_data=3C.
//  BB,1F -> rd_en 1 cycle, addr=F (upper bits dropped); no other strobe.
//  CC,12,34,02 -> op_wr=alu_en=1 same cycle, op_a=12, op_b=34, alu_fun=2; DD,07 -> alu_en, alu_fun=7,
//   op_a/op_b still 12/34.
//  AA,05 then TIMEOUT idle cycles -> frame_err 1 cycle, busy=0, no wr_en; next AA,01,FF -> write ok.
//  CC,12 then byte with rx_err=1 -> frame_err, IDLE; 0x55 in IDLE -> cmd_err only.
//  Assert rst mid-frame (after AA,05) -> all outputs 0 immediately; DD,03 after release -> alu_en.

Source files
------------

// File: rtl/uart_rx_cmd_parser_if.sv
// rtl/uart_rx_cmd_parser_if.sv - receive-byte and command-strobe bundle for uart_rx_cmd_parser
//
// Purpose: groups the UART receiver byte stream and the decoded command outputs.
// master: drives rx_data/rx_valid/rx_err, observes decoded strobes and data.
// slave : the parser; consumes the byte stream, drives strobes, data, busy and error pulses.
interface uart_rx_cmd_parser_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_err;
  logic              wr_en;
  logic              rd_en;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wr_data;
  logic              op_wr;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic              alu_en;
  logic [3:0]        alu_fun;
  logic              busy;
  logic              cmd_err;
  logic              frame_err;

  modport master (
    output rx_data, rx_valid, rx_err,
    input  wr_en, rd_en, addr, wr_data, op_wr, op_a, op_b, alu_en, alu_fun,
           busy, cmd_err, frame_err
  );

  modport slave (
    input  rx_data, rx_valid, rx_err,
    output wr_en, rd_en, addr, wr_data, op_wr, op_a, op_b, alu_en, alu_fun,
           busy, cmd_err, frame_err
  );
endinterface

// File: rtl/uart_rx_cmd_parser.sv
// rtl/uart_rx_cmd_parser.sv - decodes UART command frames into register and ALU strobes
//
// Purpose: frame decoder between the UART receiver and the register file / ALU.
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-high reset
//   bus  - uart_rx_cmd_parser_if.slave: rx_data/rx_valid/rx_err in; wr_en, rd_en, addr,
//          wr_data, op_wr, op_a, op_b, alu_en, alu_fun, busy, cmd_err, frame_err out
// Frames: AA addr data (write), BB addr (read), CC a b fun (load+exec), DD fun (exec).
module uart_rx_cmd_parser #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic                  clk,
  input  logic                  rst,
  uart_rx_cmd_parser_if.slave   bus
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  TMO_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [DATA_W-1:0] CMD_WR  = DATA_W'(8'hAA);
  localparam logic [DATA_W-1:0] CMD_RD  = DATA_W'(8'hBB);
  localparam logic [DATA_W-1:0] CMD_ALU = DATA_W'(8'hCC);
  localparam logic [DATA_W-1:0] CMD_EXE = DATA_W'(8'hDD);

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    RD_ADDR,
    ALU_A,
    ALU_B,
    ALU_FUN_OP,
    ALU_FUN_NOP
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  tmo_q, tmo_d;

  // Staging registers hold the partial frame so the visible data outputs
  // only change together with the strobe that qualifies them.
  logic [ADDR_W-1:0] addr_stg_q, addr_stg_d;
  logic [DATA_W-1:0] opa_stg_q, opa_stg_d;
  logic [DATA_W-1:0] opb_stg_q, opb_stg_d;

  logic              wr_en_q, wr_en_d;
  logic              rd_en_q, rd_en_d;
  logic              op_wr_q, op_wr_d;
  logic              alu_en_q, alu_en_d;
  logic              cmd_err_q, cmd_err_d;
  logic              frame_err_q, frame_err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [DATA_W-1:0] op_a_q, op_a_d;
  logic [DATA_W-1:0] op_b_q, op_b_d;
  logic [3:0]        alu_fun_q, alu_fun_d;

  logic              timeout_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      tmo_q       <= '0;
      addr_stg_q  <= '0;
      opa_stg_q   <= '0;
      opb_stg_q   <= '0;
      wr_en_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      op_wr_q     <= 1'b0;
      alu_en_q    <= 1'b0;
      cmd_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
      addr_q      <= '0;
      wr_data_q   <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      alu_fun_q   <= '0;
    end else begin
      state_q     <= state_d;
      tmo_q       <= tmo_d;
      addr_stg_q  <= addr_stg_d;
      opa_stg_q   <= opa_stg_d;
      opb_stg_q   <= opb_stg_d;
      wr_en_q     <= wr_en_d;
      rd_en_q     <= rd_en_d;
      op_wr_q     <= op_wr_d;
      alu_en_q    <= alu_en_d;
      cmd_err_q   <= cmd_err_d;
      frame_err_q <= frame_err_d;
      addr_q      <= addr_d;
      wr_data_q   <= wr_data_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      alu_fun_q   <= alu_fun_d;
    end
  end

  // An arriving byte always takes priority over an expiring timeout.
  assign timeout_hit = (state_q != IDLE) && !bus.rx_valid && (tmo_q == TMO_LAST);

  always_comb begin
    state_d     = state_q;
    addr_stg_d  = addr_stg_q;
    opa_stg_d   = opa_stg_q;
    opb_stg_d   = opb_stg_q;
    wr_en_d     = 1'b0;
    rd_en_d     = 1'b0;
    op_wr_d     = 1'b0;
    alu_en_d    = 1'b0;
    cmd_err_d   = 1'b0;
    frame_err_d = 1'b0;
    addr_d      = addr_q;
    wr_data_d   = wr_data_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    alu_fun_d   = alu_fun_q;

    // Inter-byte idle counter; holds at its last value rather than wrapping.
    if ((state_q == IDLE) || bus.rx_valid) begin
      tmo_d = '0;
    end else if (tmo_q != TMO_LAST) begin
      tmo_d = tmo_q + 1'b1;
    end else begin
      tmo_d = tmo_q;
    end

    if (bus.rx_valid) begin
      if (bus.rx_err) begin
        // Corrupted byte: drop it and whatever partial frame was in progress.
        frame_err_d = 1'b1;
        state_d     = IDLE;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (bus.rx_data == CMD_WR) begin
              state_d = WR_ADDR;
            end else if (bus.rx_data == CMD_RD) begin
              state_d = RD_ADDR;
            end else if (bus.rx_data == CMD_ALU) begin
              state_d = ALU_A;
            end else if (bus.rx_data == CMD_EXE) begin
              state_d = ALU_FUN_NOP;
            end else begin
              cmd_err_d = 1'b1;
            end
          end
          WR_ADDR: begin
            addr_stg_d = bus.rx_data[ADDR_W-1:0];
            state_d    = WR_DATA;
          end
          WR_DATA: begin
            wr_en_d   = 1'b1;
            addr_d    = addr_stg_q;
            wr_data_d = bus.rx_data;
            state_d   = IDLE;
          end
          RD_ADDR: begin
            rd_en_d = 1'b1;
            addr_d  = bus.rx_data[ADDR_W-1:0];
            state_d = IDLE;
          end
          ALU_A: begin
            opa_stg_d = bus.rx_data;
            state_d   = ALU_B;
          end
          ALU_B: begin
            opb_stg_d = bus.rx_data;
            state_d   = ALU_FUN_OP;
          end
          ALU_FUN_OP: begin
            op_wr_d   = 1'b1;
            alu_en_d  = 1'b1;
            op_a_d    = opa_stg_q;
            op_b_d    = opb_stg_q;
            alu_fun_d = bus.rx_data[3:0];
            state_d   = IDLE;
          end
          ALU_FUN_NOP: begin
            alu_en_d  = 1'b1;
            alu_fun_d = bus.rx_data[3:0];
            state_d   = IDLE;
          end
          default: begin
            state_d = IDLE;
          end
        endcase
      end
    end else if (timeout_hit) begin
      frame_err_d = 1'b1;
      state_d     = IDLE;
    end
  end

  assign bus.wr_en     = wr_en_q;
  assign bus.rd_en     = rd_en_q;
  assign bus.addr      = addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.op_wr     = op_wr_q;
  assign bus.op_a      = op_a_q;
  assign bus.op_b      = op_b_q;
  assign bus.alu_en    = alu_en_q;
  assign bus.alu_fun   = alu_fun_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.cmd_err   = cmd_err_q;
  assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx_cmd_parser.sv
// tb/tb_uart_rx_cmd_parser.sv - self-checking bench for uart_rx_cmd_parser
module tb_uart_rx_cmd_parser;

  localparam int TMO = 8;

  logic clk;
  logic rst;

  uart_rx_cmd_parser_if #(.DATA_W(8), .ADDR_W(4)) bus_if ();

  uart_rx_cmd_parser #(.DATA_W(8), .ADDR_W(4), .TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: collects bytes of the current frame and decides what
  // the outputs must be one cycle later.
  logic [7:0] frame[$];
  int         idle_cnt = 0;
  logic       e_wr = 0, e_rd = 0, e_opwr = 0, e_alu = 0, e_cerr = 0, e_ferr = 0, e_busy = 0;
  logic [3:0] e_addr = 0, e_fun = 0;
  logic [7:0] e_wdata = 0, e_opa = 0, e_opb = 0;

  function automatic int frame_len(input logic [7:0] c);
    case (c)
      8'hAA:   return 3;
      8'hBB:   return 2;
      8'hCC:   return 4;
      8'hDD:   return 2;
      default: return 0;
    endcase
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        frame.delete();
        idle_cnt = 0;
        {e_wr, e_rd, e_opwr, e_alu, e_cerr, e_ferr, e_busy} = '0;
        e_addr = 0; e_fun = 0; e_wdata = 0; e_opa = 0; e_opb = 0;
      end else begin
        {e_wr, e_rd, e_opwr, e_alu, e_cerr, e_ferr} = '0;
        if (bus_if.rx_valid) begin
          idle_cnt = 0;
          if (bus_if.rx_err) begin
            e_ferr = 1;
            frame.delete();
          end else begin
            frame.push_back(bus_if.rx_data);
            if (frame_len(frame[0]) == 0) begin
              e_cerr = 1;
              frame.delete();
            end else if (frame.size() == frame_len(frame[0])) begin
              case (frame[0])
                8'hAA: begin e_wr = 1; e_addr = frame[1][3:0]; e_wdata = frame[2]; end
                8'hBB: begin e_rd = 1; e_addr = frame[1][3:0]; end
                8'hCC: begin e_opwr = 1; e_alu = 1; e_opa = frame[1]; e_opb = frame[2];
                             e_fun = frame[3][3:0]; end
                default: begin e_alu = 1; e_fun = frame[1][3:0]; end
              endcase
              frame.delete();
            end
          end
        end else if (frame.size() > 0) begin
          idle_cnt++;
          if (idle_cnt == TMO) begin
            e_ferr = 1;
            frame.delete();
            idle_cnt = 0;
          end
        end
        e_busy = (frame.size() > 0);
      end
    end
  end

  int         wr_seen = 0, rd_seen = 0, opwr_seen = 0, alu_seen = 0, cerr_seen = 0, ferr_seen = 0;
  logic [3:0] last_addr = 0, last_fun = 0;
  logic [7:0] last_wdata = 0, last_opa = 0, last_opb = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("wr_en",     bus_if.wr_en,     e_wr);
        chk("rd_en",     bus_if.rd_en,     e_rd);
        chk("op_wr",     bus_if.op_wr,     e_opwr);
        chk("alu_en",    bus_if.alu_en,    e_alu);
        chk("cmd_err",   bus_if.cmd_err,   e_cerr);
        chk("frame_err", bus_if.frame_err, e_ferr);
        chk("busy",      bus_if.busy,      e_busy);
        if (e_wr || e_rd) chk("addr", bus_if.addr, e_addr);
        if (e_wr) chk("wr_data", bus_if.wr_data, e_wdata);
        if (e_opwr) begin
          chk("op_a", bus_if.op_a, e_opa);
          chk("op_b", bus_if.op_b, e_opb);
        end
        if (e_alu) chk("alu_fun", bus_if.alu_fun, e_fun);
        if (bus_if.wr_en)  begin wr_seen++; last_addr = bus_if.addr; last_wdata = bus_if.wr_data; end
        if (bus_if.rd_en)  begin rd_seen++; last_addr = bus_if.addr; end
        if (bus_if.op_wr)  begin opwr_seen++; last_opa = bus_if.op_a; last_opb = bus_if.op_b; end
        if (bus_if.alu_en) begin alu_seen++; last_fun = bus_if.alu_fun; end
        if (bus_if.cmd_err)   cerr_seen++;
        if (bus_if.frame_err) ferr_seen++;
      end
    end
  end

  // Stimulus steps are aligned 2 time units after a rising edge.
  task automatic send(input logic [7:0] b, input logic err, input int gap);
    bus_if.rx_valid = 1'b1;
    bus_if.rx_data  = b;
    bus_if.rx_err   = err;
    @(posedge clk); #2;
    bus_if.rx_valid = 1'b0;
    bus_if.rx_err   = 1'b0;
    repeat (gap) begin @(posedge clk); #2; end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus_if.rx_valid = 1'b0;
    bus_if.rx_err   = 1'b0;
    bus_if.rx_data  = 8'h00;
    idle(3);
    chk("rst_busy",      bus_if.busy,      0);
    chk("rst_wr_en",     bus_if.wr_en,     0);
    chk("rst_frame_err", bus_if.frame_err, 0);
    chk("rst_addr",      bus_if.addr,      0);
    chk("rst_op_a",      bus_if.op_a,      0);
    rst = 1'b0;
    idle(2);

    send(8'hAA, 0, 3); send(8'h05, 0, 3); send(8'h3C, 0, 2);
    chk("wr_count1", wr_seen, 1);
    chk("wr_addr1",  last_addr, 4'h5);
    chk("wr_data1",  last_wdata, 8'h3C);

    send(8'hBB, 0, 0); send(8'h1F, 0, 2);
    chk("rd_count1", rd_seen, 1);
    chk("rd_addr1",  last_addr, 4'hF);
    chk("wr_count_after_rd", wr_seen, 1);

    send(8'hCC, 0, 0); send(8'h12, 0, 1); send(8'h34, 0, 0); send(8'h02, 0, 2);
    chk("opwr_count1", opwr_seen, 1);
    chk("alu_count1",  alu_seen, 1);
    chk("op_a1",       last_opa, 8'h12);
    chk("op_b1",       last_opb, 8'h34);
    chk("alu_fun1",    last_fun, 4'h2);

    send(8'hDD, 0, 0); send(8'h07, 0, 2);
    chk("alu_count2",  alu_seen, 2);
    chk("alu_fun2",    last_fun, 4'h7);
    chk("opwr_count2", opwr_seen, 1);
    chk("op_a_hold",   bus_if.op_a, 8'h12);
    chk("op_b_hold",   bus_if.op_b, 8'h34);

    send(8'hAA, 0, 0); send(8'h05, 0, TMO + 2);
    chk("tmo_ferr",  ferr_seen, 1);
    chk("tmo_busy",  bus_if.busy, 0);
    chk("tmo_no_wr", wr_seen, 1);
    send(8'hAA, 0, 0); send(8'h01, 0, 0); send(8'hFF, 0, 2);
    chk("wr_count2", wr_seen, 2);
    chk("wr_addr2",  last_addr, 4'h1);
    chk("wr_data2",  last_wdata, 8'hFF);

    // Gaps of TMO-1 idle cycles: the byte lands on the expiry cycle and wins.
    send(8'hAA, 0, TMO - 1); send(8'h09, 0, TMO - 1); send(8'h5A, 0, 2);
    chk("edge_wr_count", wr_seen, 3);
    chk("edge_ferr",     ferr_seen, 1);
    chk("edge_addr",     last_addr, 4'h9);
    chk("edge_data",     last_wdata, 8'h5A);

    send(8'hCC, 0, 0); send(8'h12, 0, 0); send(8'h77, 1, 2);
    chk("err_ferr",     ferr_seen, 2);
    chk("err_no_alu",   alu_seen, 2);
    send(8'h55, 0, 2);
    chk("cmd_err_cnt",  cerr_seen, 1);
    chk("cmd_err_ferr", ferr_seen, 2);
    send(8'h3A, 1, 2);
    chk("idle_err_ferr", ferr_seen, 3);

    // Next command arrives in the same cycle the previous strobe is high.
    send(8'hBB, 0, 0); send(8'h03, 0, 0); send(8'hDD, 0, 0); send(8'h04, 0, 2);
    chk("b2b_rd",  rd_seen, 2);
    chk("b2b_alu", alu_seen, 3);
    chk("b2b_fun", last_fun, 4'h4);

    send(8'hAA, 0, 0); send(8'h05, 0, 0);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy",    bus_if.busy,    0);
    chk("mid_rst_addr",    bus_if.addr,    0);
    chk("mid_rst_op_a",    bus_if.op_a,    0);
    chk("mid_rst_alu_fun", bus_if.alu_fun, 0);
    chk("mid_rst_wr_data", bus_if.wr_data, 0);
    #1;
    idle(2);
    rst = 1'b0;
    idle(1);
    send(8'hDD, 0, 0); send(8'h03, 0, 2);
    chk("post_rst_alu", alu_seen, 4);
    chk("post_rst_fun", last_fun, 4'h3);
    chk("post_rst_wr",  wr_seen, 3);

    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
